// File: rtl/glb_psum_accum_ctrl_pkg.sv
// Shared types and constants for the GLB psum accumulation controller.
package glb_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DATA_BW = 16;
  localparam int ADDR_BW = 10;
  localparam int CNT_BW  = 16;
  // Stage 1 valid plus the forward-register valid trailing one cycle behind it.
  localparam int STAGES  = 1;

  localparam logic signed [DATA_BW-1:0] PSUM_MAX = 16'sh7FFF;
  localparam logic signed [DATA_BW-1:0] PSUM_MIN = 16'sh8000;

endpackage

// File: rtl/glb_psum_accum_ctrl_psum_sat_add.sv
// Signed psum adder: widened by one bit, then clamped or wrapped depending on SATURATE.
module psum_sat_add #(
  parameter int DATA_BITWIDTH = 16,
  parameter bit SATURATE      = 1'b1
) (
  input  logic signed [DATA_BITWIDTH-1:0] a_i,
  input  logic signed [DATA_BITWIDTH-1:0] b_i,
  output logic signed [DATA_BITWIDTH-1:0] sum_o,
  output logic                            ovf_o
);

  localparam int W = DATA_BITWIDTH;
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  logic [W:0] wide;

  always_comb begin
    wide  = {a_i[W-1], a_i} + {b_i[W-1], b_i};
    // Sign bit and the bit above it disagree exactly when the W-bit result overflowed.
    ovf_o = wide[W] ^ wide[W-1];
    sum_o = wide[W-1:0];
    if (SATURATE && ovf_o) sum_o = wide[W] ? SMIN : SMAX;
  end

endmodule

// File: rtl/glb_psum_accum_ctrl.sv
// Read-modify-write sequencer feeding the GLB psum port: read, add, write back,
// with a one-entry forward register covering back-to-back same-address psums.
module glb_psum_accum_ctrl
  import glb_pkg::*;
#(
  parameter int DATA_BITWIDTH = DATA_BW,
  parameter int ADDR_BITWIDTH = ADDR_BW,
  parameter int CNT_BITWIDTH  = CNT_BW,
  parameter bit SATURATE      = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_BITWIDTH-1:0]  cfg_count,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_BITWIDTH-1:0] in_addr,
  input  logic [DATA_BITWIDTH-1:0] in_data,
  input  logic                     in_first,
  output logic                     read_req_psum,
  output logic [ADDR_BITWIDTH-1:0] r_addr_psum,
  input  logic [DATA_BITWIDTH-1:0] r_data_psum,
  output logic                     write_en_psum,
  output logic [ADDR_BITWIDTH-1:0] w_addr_psum,
  output logic [DATA_BITWIDTH-1:0] w_data_psum,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf
);

  state_e                   state_q, state_d;
  logic [CNT_BITWIDTH-1:0]  cnt_q, cnt_d, cfg_q, cfg_d;
  logic                     ovf_q, ovf_d;
  logic [STAGES:0]          vld_pipe_q;
  logic [ADDR_BITWIDTH-1:0] s1_addr_q, fwd_addr_q;
  logic [DATA_BITWIDTH-1:0] s1_data_q, fwd_data_q, old_data, sum;
  logic                     s1_first_q, add_ovf, hs;

  assign in_ready      = (state_q == RUN) && (cnt_q < cfg_q);
  assign hs            = in_valid && in_ready;
  assign read_req_psum = hs && !in_first;
  assign r_addr_psum   = in_addr;

  // The GLB returns stale data when the previous psum writes the same address this cycle.
  always_comb begin
    old_data = r_data_psum;
    if (s1_first_q)
      old_data = '0;
    else if (vld_pipe_q[1] && (fwd_addr_q == s1_addr_q))
      old_data = fwd_data_q;
  end

  psum_sat_add #(
    .DATA_BITWIDTH (DATA_BITWIDTH),
    .SATURATE      (SATURATE)
  ) u_add (
    .a_i   (old_data),
    .b_i   (s1_data_q),
    .sum_o (sum),
    .ovf_o (add_ovf)
  );

  assign write_en_psum = vld_pipe_q[0];
  assign w_addr_psum   = s1_addr_q;
  assign w_data_psum   = vld_pipe_q[0] ? sum : '0;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign ovf           = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        cfg_d   = cfg_count;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = (cfg_count == '0) ? DONE : RUN;
      end
      RUN: begin
        if (hs) cnt_d = cnt_q + CNT_BITWIDTH'(1);
        if (cnt_q == cfg_q) state_d = DRAIN;
      end
      DRAIN: if (!vld_pipe_q[0]) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (vld_pipe_q[0] && add_ovf) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cfg_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_q <= '0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_first_q <= 1'b0;
      fwd_addr_q <= '0;
      fwd_data_q <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], hs};
      if (hs) begin
        s1_addr_q  <= in_addr;
        s1_data_q  <= in_data;
        s1_first_q <= in_first;
      end
      if (vld_pipe_q[0]) begin
        fwd_addr_q <= s1_addr_q;
        fwd_data_q <= sum;
      end
    end
  end

endmodule

// File: doc/glb_psum_accum_ctrl.md
Name: glb_psum_accum_ctrl

Overview:
- Read-modify-write sequencer directly upstream of the psum port of the GLB cluster.
- Accepts a stream of partial sums from the PE array, each with a GLB address.
- For each psum: issues `read_req_psum`, adds the returned value, writes the sum back through `write_en_psum`.
- Counts a programmed number of accumulations per pass and pulses `done`. Forwards in-flight results so back-to-back accesses to the same address are correct.

Parameters:
- DATA_BITWIDTH, 16, psum width; matches GLB cluster.
- ADDR_BITWIDTH, 10, GLB psum address width.
- CNT_BITWIDTH, 16, width of per-pass accumulation count.
- SATURATE, 1, 1 = signed saturating add; 0 = two's-complement wrap.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a pass; ignored unless IDLE.
- cfg_count  input  CNT_BITWIDTH  number of psums to accept this pass; sampled on start.
- in_valid  input  1  incoming psum valid.
- in_ready  output  1  block can accept psum this cycle.
- in_addr  input  ADDR_BITWIDTH  GLB address of psum.
- in_data  input  DATA_BITWIDTH  signed psum.
- in_first  input  1  first contribution to this address; skip read, treat stored value as 0.
- read_req_psum  output  1  GLB psum read request.
- r_addr_psum  output  ADDR_BITWIDTH  GLB read address.
- r_data_psum  input  DATA_BITWIDTH  GLB read data, valid the cycle after read_req_psum.
- write_en_psum  output  1  GLB psum write enable.
- w_addr_psum  output  ADDR_BITWIDTH  GLB write address.
- w_data_psum  output  DATA_BITWIDTH  GLB write data.
- busy  output  1  high in RUN or DRAIN.
- done  output  1  one-cycle pulse at end of pass.
- ovf  output  1  sticky: any add saturated/overflowed this pass; cleared on start.

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM = IDLE, counters, pipeline valid bits and forward register cleared. Reset mid-pass aborts it; no write is completed afterwards.
- FSM states:
  - IDLE -> RUN on start. If cfg_count == 0, go IDLE -> DONE directly.
  - RUN -> DRAIN when accepted count reaches cfg_count.
  - DRAIN -> DONE when stage-1 valid is 0.
  - DONE -> IDLE after one cycle; done = 1 in DONE only.
- in_ready = (state == RUN) && (accepted < cfg_count). Handshake is in_valid && in_ready. No backpressure from the GLB; throughput is 1 psum/cycle.
- Stage 0, accept cycle t:
  - read_req_psum = handshake && !in_first; r_addr_psum = in_addr (combinational).
  - Register addr, data, first, valid into stage 1.
- Stage 1, cycle t+1:
  - old = 0 if first.
  - Otherwise old = fwd_data if fwd_valid && fwd_addr == s1_addr.
  - Otherwise old = r_data_psum.
  - sum = old + s1_data.
  - write_en_psum = s1_valid; w_addr_psum = s1_addr; w_data_psum = sum (combinational from stage-1 registers and r_data_psum).
- Forward register:
  - Captures {s1_addr, sum} whenever s1_valid; fwd_valid follows s1_valid.
  - The GLB returns old data on same-cycle read/write to the same address; the forward register covers this case, so consecutive same-address psums accumulate correctly.
- Arithmetic:
  - Signed, DATA_BITWIDTH+1 internal sum.
  - SATURATE=1: clamp to max/min signed value and set ovf.
  - SATURATE=0: truncate to DATA_BITWIDTH; set ovf on signed overflow.
- start while busy is ignored. in_valid outside RUN is ignored (in_ready = 0).
- Latency: handshake at t -> write at t+1; done two cycles after the final write (DRAIN then DONE).

Decomposition:
- Shared package glb_pkg:
  - state enum {IDLE, RUN, DRAIN, DONE}.
  - Width localparams and the signed min/max constants.
- One sub-module, psum_sat_add (combinational adder with saturation and overflow flag, parameterised by DATA_BITWIDTH and SATURATE), instantiated once in stage 1.

Test Plan:
- First write: start, cfg_count=1; psum addr 5, data 7, in_first=1 -> no read_req; write addr 5 data 7 at t+1; done pulse; ovf=0.
- Accumulate: GLB addr 5 holds 7; psum addr 5, data -3, first=0 -> read_req at t with r_addr 5; write data 4 at t+1.
- Back-to-back hazard: cfg_count=3; addr 9 holds 0; three consecutive psums addr 9, data 1/2/3, first=0 -> writes 1, 3, 6 on consecutive cycles.
- Saturation (SATURATE=1): stored 32767 + 5 -> write 32767, ovf=1. Next start clears ovf.
- Flow control: cfg_count=2; present three valid psums -> in_ready drops after the second; third not accepted; exactly two writes; done follows.
- Reset mid-pass: assert reset low one cycle after a handshake -> write_en_psum, busy, in_ready immediately 0; after release, IDLE and done not pulsed.
